// File: rtl/qbus_pkg.sv
// Shared QBUS definitions: cycle state encoding, DAL/data widths, I/O page match value.
package qbus_pkg;

  localparam int DAL_W     = 22;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 16;
  localparam int IO_PAGE_W = 9;
  localparam logic [IO_PAGE_W-1:0] IO_PAGE = 9'o777;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    DSETUP,
    WAIT,
    END,
    RELEASE
  } qstate_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; 2-clock latency, no backpressure.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qmaster_cycle.sv
// QBUS master for one DATI/DATO cycle; strobe after ADDR_SETUP+ADDR_HOLD(+DATA_SETUP) clocks, req only taken in IDLE.
// Reply handshake waits on synchronized RRPLY; QMASTER_TIMEOUT_EN adds a TIMEOUT-clock bus-error abort.
module qmaster_cycle
  import qbus_pkg::*;
#(
  parameter int ADDR_SETUP = 2,
  parameter int ADDR_HOLD  = 2,
  parameter int DATA_SETUP = 2,
  parameter int TIMEOUT    = 500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [DAL_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [DAL_W-1:0]  TDAL,
  output logic              DALtx,
  input  logic [DAL_W-1:0]  RDAL,
  output logic              TSYNC,
  output logic              TDIN,
  output logic              TDOUT,
  output logic              TBS7,
  output logic              TWTBT,
  input  logic              RRPLY
);

  localparam logic [CNT_W-1:0] AS_LAST = CNT_W'(ADDR_SETUP - 1);
  localparam logic [CNT_W-1:0] AH_LAST = CNT_W'(ADDR_HOLD - 1);
  localparam logic [CNT_W-1:0] DS_LAST = CNT_W'(DATA_SETUP - 1);

  qstate_t           state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DAL_W-1:0]  addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              rply_s;
  logic              capture;
  logic              io_page;
  logic [DAL_W-1:0]  data_dal;
  logic              unused_rdal;

  assign io_page     = (addr_q[DAL_W-1:DAL_W-IO_PAGE_W] == IO_PAGE);
  assign data_dal    = {{(DAL_W-DATA_W){1'b0}}, wdata_q};
  assign unused_rdal = ^RDAL[DAL_W-1:DATA_W];

  sync2 u_rply_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (RRPLY),
    .q     (rply_s)
  );

`ifdef QMASTER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  logic to_q;
  logic timeout_hit;

  // Remembers that the RELEASE pulse being issued is a bus-error abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              to_q <= 1'b0;
    else if (timeout_hit)      to_q <= 1'b1;
    else if (state == RELEASE) to_q <= 1'b0;
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
      end
      if (capture) rdata <= RDAL[DATA_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    TDAL      = '0;
    DALtx     = 1'b0;
    TSYNC     = 1'b0;
    TDIN      = 1'b0;
    TDOUT     = 1'b0;
    TBS7      = 1'b0;
    TWTBT     = 1'b0;
`ifdef QMASTER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = ADDR;
          cnt_nxt   = '0;
        end
      end
      ADDR: begin
        DALtx = 1'b1;
        TDAL  = addr_q;
        TBS7  = io_page;
        TWTBT = we_q;
        if (cnt == AS_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        TSYNC = 1'b1;
        DALtx = 1'b1;
        TDAL  = addr_q;
        TBS7  = io_page;
        TWTBT = we_q;
        if (cnt == AH_LAST) begin
          state_nxt = we_q ? DSETUP : WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DSETUP: begin
        TSYNC = 1'b1;
        DALtx = 1'b1;
        TDAL  = data_dal;
        if (cnt == DS_LAST) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        // A reply already present on entry completes on this sample; no edge needed.
        TSYNC = 1'b1;
        TDIN  = !we_q;
        TDOUT = we_q;
        DALtx = we_q;
        TDAL  = we_q ? data_dal : '0;
        if (rply_s) begin
          state_nxt = END;
          capture   = !we_q;
        end
      end
      END: begin
        TSYNC = 1'b1;
        DALtx = we_q;
        TDAL  = we_q ? data_dal : '0;
        if (!rply_s) state_nxt = RELEASE;
      end
      RELEASE: begin
        done      = 1'b1;
        state_nxt = IDLE;
`ifdef QMASTER_TIMEOUT_EN
        err = to_q;
`endif
      end
      default: state_nxt = IDLE;
    endcase

`ifdef QMASTER_TIMEOUT_EN
    // Timeout spans WAIT and END together and overrides a reply arriving on the same clock.
    if (state == WAIT || state == END) begin
      cnt_nxt = cnt + CNT_W'(1);
      if (cnt == TO_LAST) begin
        state_nxt   = RELEASE;
        capture     = 1'b0;
        timeout_hit = 1'b1;
      end
    end
`endif
  end

endmodule
